full_adder_core: RTL and testbench

Registered, parameterisable-width ripple-carry adder built from 1-bit full-adder cells. Computes sum = in_bit1 + in_bit2 + in_carry.
- Presents out_sum and out_carry one clock after a valid input.
- Used as the arithmetic leaf in datapaths needing a registered add with carry-in/carry-out.
- WIDTH=1 gives the classic single-bit full adder with registered outputs.

---
 rtl/full_adder_pkg.sv | 9 +
 rtl/full_adder_bit.sv | 12 +
 rtl/full_adder_core.sv | 70 +++++++
 tb/tb_full_adder_core.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and result type for the registered ripple-carry adder
package full_adder_pkg;
  localparam int FA_DEFAULT_WIDTH = 8;
  localparam int FA_MAX_WIDTH = 64;
  typedef struct packed {
    logic carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full-adder cell
// Ports: a, b, cin operand and carry-in bits; s sum bit; cout carry-out bit.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder_core.sv
// full_adder_core: registered WIDTH-bit ripple-carry adder, {out_carry,out_sum} = in_bit1 + in_bit2 + in_carry
// Ports: in_clk clock; in_rst sync active-high reset; in_valid/in_bit1/in_bit2/in_carry operands;
//        out_valid/out_sum/out_carry registered result one cycle after a valid input.
// Optional: FULL_ADDER_OVF_EN adds out_overflow, the registered two's-complement overflow flag.
module full_adder_core
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bit1,
  input  logic [WIDTH-1:0] in_bit2,
  input  logic             in_carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             out_overflow
`endif
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] s;
  assign c[0] = in_carry;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a(in_bit1[i]),
      .b(in_bit2[i]),
      .cin(c[i]),
      .s(s[i]),
      .cout(c[i+1])
    );
  end
  logic valid_d, valid_q, carry_d, carry_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  // Holding through the mux keeps operand X out of the registers when not valid.
  always_comb begin
    valid_d = in_valid;
    sum_d = in_valid ? s : sum_q;
    carry_d = in_valid ? c[WIDTH] : carry_q;
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      valid_q <= 1'b0;
      sum_q <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
    end
  end
  assign out_valid = valid_q;
  assign out_sum = sum_q;
  assign out_carry = carry_q;
`ifdef FULL_ADDER_OVF_EN
  logic ovf_d, ovf_q;
  // For WIDTH=1, c[WIDTH-1] is c[0], i.e. in_carry.
  always_comb begin
    ovf_d = in_valid ? (c[WIDTH] ^ c[WIDTH-1]) : ovf_q;
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign out_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: self-checking bench for full_adder_core at WIDTH=1 and WIDTH=8
module tb_full_adder_core;
  import full_adder_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v1_in, a1, b1, c1, v1_out, s1_out, co1_out;
  logic       v8_in, c8, v8_out, co8_out;
  logic [7:0] a8, b8, s8_out;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf8;
`endif

  full_adder_core #(.WIDTH(1)) u1 (
    .in_clk(clk), .in_rst(rst), .in_valid(v1_in),
    .in_bit1(a1), .in_bit2(b1), .in_carry(c1),
    .out_valid(v1_out), .out_sum(s1_out), .out_carry(co1_out)
`ifdef FULL_ADDER_OVF_EN
    , .out_overflow(ovf1)
`endif
  );

  full_adder_core #(.WIDTH(8)) u8 (
    .in_clk(clk), .in_rst(rst), .in_valid(v8_in),
    .in_bit1(a8), .in_bit2(b8), .in_carry(c8),
    .out_valid(v8_out), .out_sum(s8_out), .out_carry(co8_out)
`ifdef FULL_ADDER_OVF_EN
    , .out_overflow(ovf8)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a, b, c, s, co;
  } v1_t;
  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] s;
    logic       co, ovf;
  } v8_t;

  v1_t tab1[8];
  v8_t tab8[6];
  fa_result_t ref_r;
  logic [8:0] r9;
  logic exp_ovf;

  initial begin
    tab1[0] = '{0, 0, 0, 0, 0};
    tab1[1] = '{0, 0, 1, 1, 0};
    tab1[2] = '{0, 1, 0, 1, 0};
    tab1[3] = '{0, 1, 1, 0, 1};
    tab1[4] = '{1, 0, 0, 1, 0};
    tab1[5] = '{1, 0, 1, 0, 1};
    tab1[6] = '{1, 1, 0, 0, 1};
    tab1[7] = '{1, 1, 1, 1, 1};
    tab8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tab8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tab8[2] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    tab8[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tab8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tab8[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

    v1_in = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8_in = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
    step();
    step();
    check("rst_v1", 64'(v1_out), 64'd0);
    check("rst_s1", 64'(s1_out), 64'd0);
    check("rst_co1", 64'(co1_out), 64'd0);
    check("rst_v8", 64'(v8_out), 64'd0);
    check("rst_s8", 64'(s8_out), 64'd0);
    check("rst_co8", 64'(co8_out), 64'd0);
`ifdef FULL_ADDER_OVF_EN
    check("rst_ovf8", 64'(ovf8), 64'd0);
    check("rst_ovf1", 64'(ovf1), 64'd0);
`endif
    rst = 1'b0;
    v8_in = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v1_in = 1'b1; a1 = tab1[i].a; b1 = tab1[i].b; c1 = tab1[i].c;
      step();
      check("w1_valid", 64'(v1_out), 64'd1);
      check("w1_sum", 64'(s1_out), 64'(tab1[i].s));
      check("w1_carry", 64'(co1_out), 64'(tab1[i].co));
`ifdef FULL_ADDER_OVF_EN
      check("w1_ovf", 64'(ovf1), 64'(tab1[i].co ^ tab1[i].c));
`endif
    end
    v1_in = 1'b0;

    for (int i = 0; i < 6; i++) begin
      v8_in = 1'b1; a8 = tab8[i].a; b8 = tab8[i].b; c8 = tab8[i].c;
      step();
      check("w8_valid", 64'(v8_out), 64'd1);
      check("w8_sum", 64'(s8_out), 64'(tab8[i].s));
      check("w8_carry", 64'(co8_out), 64'(tab8[i].co));
`ifdef FULL_ADDER_OVF_EN
      check("w8_ovf", 64'(ovf8), 64'(tab8[i].ovf));
`endif
    end

    v8_in = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
    step();
    check("gap_valid", 64'(v8_out), 64'd1);
    check("gap_sum", 64'(s8_out), 64'h30);
    for (int k = 0; k < 2; k++) begin
      v8_in = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      step();
      check("gap_hold_valid", 64'(v8_out), 64'd0);
      check("gap_hold_sum", 64'(s8_out), 64'h30);
      check("gap_hold_carry", 64'(co8_out), 64'd0);
    end

    v8_in = 1'b1; a8 = 8'hF0; b8 = 8'h22; c8 = 1'b1; rst = 1'b1;
    step();
    check("midrst_valid", 64'(v8_out), 64'd0);
    check("midrst_sum", 64'(s8_out), 64'd0);
    check("midrst_carry", 64'(co8_out), 64'd0);
    rst = 1'b0; a8 = 8'h03; b8 = 8'h04; c8 = 1'b0;
    step();
    check("postrst_valid", 64'(v8_out), 64'd1);
    check("postrst_sum", 64'(s8_out), 64'h07);
    check("postrst_carry", 64'(co8_out), 64'd0);

    for (int n = 0; n < 1000; n++) begin
      v8_in = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
      r9 = 9'(a8) + 9'(b8) + 9'(c8);
      ref_r = '0;
      ref_r.carry = r9[8];
      ref_r.sum = 64'(r9[7:0]);
      exp_ovf = (a8[7] == b8[7]) && (r9[7] != a8[7]);
      step();
      check("rnd_valid", 64'(v8_out), 64'd1);
      check("rnd_sum", 64'(s8_out), ref_r.sum);
      check("rnd_carry", 64'(co8_out), 64'(ref_r.carry));
`ifdef FULL_ADDER_OVF_EN
      check("rnd_ovf", 64'(ovf8), 64'(exp_ovf));
`endif
    end
    v8_in = 1'b0;
    step();
    check("end_valid", 64'(v8_out), 64'd0);
    check("end_hold_sum", 64'(s8_out), ref_r.sum);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
